// File: rtl/comparator_sweeper.sv
// Self-test front end for a dual equality comparator: sweeps every operand pair,
// checks y1/y2 against the expected equality and accumulates match/error results.
module comparator_sweeper #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 y1,
  input  logic                 y2,
  output logic [WIDTH-1:0]     a1,
  output logic [WIDTH-1:0]     a2,
  output logic [WIDTH-1:0]     b1,
  output logic [WIDTH-1:0]     b2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     match_cnt,
  output logic [2*WIDTH:0]     err_cnt,
  output logic                 err_valid,
  output logic [2*WIDTH-1:0]   first_err_idx
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = 2 * WIDTH + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_inc;
  logic [SW-1:0]   settle_cnt;
  logic            settle_last;
  logic            idx_last;
  logic            expect_eq;

  assign idx_inc     = idx + IW'(1);
  assign settle_last = (settle_cnt == SW'(SETTLE - 1));
  assign idx_last    = (idx == '1);
  assign expect_eq   = (a1 == a2);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = DRIVE;
      DRIVE: begin
        busy = 1'b1;
        if (settle_last) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy      = 1'b1;
        state_nxt = idx_last ? DONE : DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are loaded from the next idx on the edge entering DRIVE, so they
  // stay constant across the whole DRIVE+SAMPLE window of that pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      settle_cnt    <= '0;
      a1            <= '0;
      a2            <= '0;
      b1            <= '0;
      b2            <= '0;
      match_cnt     <= '0;
      err_cnt       <= '0;
      err_valid     <= 1'b0;
      first_err_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx           <= '0;
          settle_cnt    <= '0;
          a1            <= '0;
          a2            <= '0;
          b1            <= '0;
          b2            <= '0;
          match_cnt     <= '0;
          err_cnt       <= '0;
          err_valid     <= 1'b0;
          first_err_idx <= '0;
        end
        DRIVE: if (!settle_last) settle_cnt <= settle_cnt + SW'(1);
        SAMPLE: begin
          if (y1 == expect_eq && y2 == expect_eq) begin
            if (expect_eq) match_cnt <= match_cnt + CW'(1);
          end else begin
            err_cnt <= err_cnt + CW'(1);
            if (!err_valid) begin
              err_valid     <= 1'b1;
              first_err_idx <= idx;
            end
          end
          if (!idx_last) begin
            idx        <= idx_inc;
            settle_cnt <= '0;
            a1         <= idx_inc[IW-1:WIDTH];
            a2         <= idx_inc[WIDTH-1:0];
            b1         <= idx_inc[WIDTH-1:0];
            b2         <= idx_inc[IW-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/comparator_sweeper.md
Name: comparator_sweeper

Overview:
Sequential stimulus and checker for the 3-bit dual equality comparator. It drives the comparator's operand inputs a1, a2, b1 and b2, and samples its y1/y2 results. On start it sweeps every (a1,a2) combination, mirrors the pair onto (b1,b2), and checks both results against the expected equality. It accumulates match and error counts and captures the first failing index. It sits beside the comparator as its self-test front end, on the opposite side of the operand/result interface.

Parameters:
WIDTH, 3, operand width; the sweep covers 2^(2*WIDTH) pairs.
SETTLE, 1, cycles the operands are held before the result sample; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a sweep; honoured only in IDLE.
y1  input  1  comparator result for the a1/a2 pair.
y2  input  1  comparator result for the b1/b2 pair.
a1  output  WIDTH  operand driven to the comparator.
a2  output  WIDTH  operand driven to the comparator.
b1  output  WIDTH  operand driven to the comparator.
b2  output  WIDTH  operand driven to the comparator.
busy  output  1  high from the cycle after start is accepted through the last SAMPLE.
done  output  1  single-cycle pulse at sweep end.
match_cnt  output  2*WIDTH+1  count of equal pairs where y1=1 and y2=1.
err_cnt  output  2*WIDTH+1  count of pairs where y1 or y2 is wrong.
err_valid  output  1  at least one error seen this sweep.
first_err_idx  output  2*WIDTH  index of the first failing pair.

Behaviour:
- Interface decided: one clock (clk); reset is synchronous and active-high (reset).
- Reset state: FSM in IDLE. All outputs are 0: a1/a2/b1/b2, busy, done, match_cnt, err_cnt, err_valid, first_err_idx. Internal idx and settle counter are 0.
- Reset mid-sweep returns to IDLE on that edge with the values above. No done pulse is produced.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 moves to DRIVE.
  - On that edge: clear match_cnt, err_cnt, err_valid and first_err_idx; set idx=0 and settle counter=0.
  - start=0 stays in IDLE.
- Operand mapping, registered from idx (2*WIDTH bits):
  - a1 = idx[2W-1:W], a2 = idx[W-1:0].
  - b1 = idx[W-1:0], b2 = idx[2W-1:W] (swapped, so equality is identical).
  - Operands are stable for the whole DRIVE+SAMPLE window of each pair.
- Expected result: exp = (a1==a2). Both y1 and y2 must equal exp.
- DRIVE: stays SETTLE cycles, using the settle counter, then moves to SAMPLE.
- SAMPLE: one cycle; y1/y2 are sampled on the edge leaving SAMPLE.
  - If y1==exp and y2==exp and exp=1: match_cnt += 1.
  - If y1!=exp or y2!=exp: err_cnt += 1. If err_valid=0, capture first_err_idx=idx and set err_valid=1.
  - If idx is all ones, go to DONE. Otherwise idx += 1 and return to DRIVE with the settle counter cleared.
- Per-pair latency is SETTLE+1 cycles.
- Total sweep: 2^(2W)*(SETTLE+1) cycles from the first DRIVE cycle to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Counters are 2W+1 bits and cannot overflow (maximum 2^(2W)). Results hold until the next accepted start.
- start while busy or in DONE is ignored; it is not queued.
- start and reset on the same edge: reset wins.
- Operands in IDLE/DONE: hold the last driven value (all ones after a full sweep). After reset they are 0.
- busy=1 in DRIVE and SAMPLE only.

Test Plan:
- Reset, ideal comparator model, SETTLE=1, start pulse at t0 -> busy from t1; done pulse at t129 (128 cycles); match_cnt=8, err_cnt=0, err_valid=0.
- Model with y1 stuck at 0 -> err_cnt=8, match_cnt=0, err_valid=1, first_err_idx=0.
- Model with y2 stuck at 1 -> err_cnt=56, match_cnt=8, first_err_idx=1 (a1=0, a2=1).
- SETTLE=3, ideal model -> done at exactly 256 cycles after the first DRIVE cycle. Each operand set is held 4 cycles. At idx=9 check a1=1, a2=1, b1=1, b2=1.
- Start re-asserted at cycle 50 of a sweep -> ignored: no restart, counters continue, single done pulse. Then reset at cycle 70 -> next edge IDLE, all outputs 0, no done pulse.
- Start and reset asserted on the same edge -> stays in IDLE, busy stays 0. Start after done -> counters clear and the sweep repeats with identical results.
